// File: rtl/rst_seq_gen_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
// Imported by the sequencer top and its synchroniser.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_DEBOUNCE,
    ST_RELEASE,
    ST_RUN
  } state_e;

  localparam int LOSS_CNT_MAX = 255;

  // Bits needed for a counter spanning 0..n-1; a 1-bit floor keeps n=1 legal.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_gen_sync2.sv
// Two-flop synchroniser with a parameterised asynchronous reset value.
module sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rst_seq_gen.sv
// Reset sequencer: debounces board reset and PLL lock, releases NCH channel
// resets in staggered order, and drives a divided clock/enable for slow logic.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int DEB_LEN   = 8,
  parameter int STAGE_DLY = 16,
  parameter int DIV       = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ext_reset_n,
  input  logic           pll_lock,
  output logic [NCH-1:0] rst_n_out,
  output logic           seq_done,
  output logic           div_clk,
  output logic           div_en,
  output logic [7:0]     lock_loss_cnt
);

  localparam int DW = cnt_w(DEB_LEN);
  localparam int SW = cnt_w(STAGE_DLY);
  localparam int IW = cnt_w(NCH);
  localparam int VW = cnt_w(DIV);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_LEN - 1);
  localparam logic [SW-1:0] STG_MAX  = SW'(STAGE_DLY - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
  localparam logic [VW-1:0] DIV_MAX  = VW'(DIV - 1);
  localparam logic [VW-1:0] DIV_HALF = VW'(DIV / 2 - 1);
  localparam logic [7:0]    LOSS_MAX = 8'(LOSS_CNT_MAX);

  logic ext_sync, lock_sync, good;

  sync2 #(.RST_VAL(1'b0)) u_sync_ext (
    .clk   (clk),
    .reset (reset),
    .d     (ext_reset_n),
    .q     (ext_sync)
  );

  sync2 #(.RST_VAL(1'b0)) u_sync_lock (
    .clk   (clk),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_sync)
  );

  assign good = ext_sync & lock_sync;

  state_e          state_q, state_d;
  logic [DW-1:0]   deb_cnt;
  logic [SW-1:0]   stage_cnt;
  logic [IW-1:0]   idx;
  logic [VW-1:0]   div_cnt;
  logic            abort, wrap, last;

  assign last = (idx == IDX_LAST);

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      ST_DEBOUNCE: begin
        if (good && deb_cnt == DEB_MAX) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (!good) begin
          abort   = 1'b1;
          state_d = ST_DEBOUNCE;
        end else if (stage_cnt == STG_MAX) begin
          wrap = 1'b1;
          if (last) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!good) begin
          abort   = 1'b1;
          state_d = ST_DEBOUNCE;
        end
      end
      default: state_d = ST_DEBOUNCE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_DEBOUNCE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt       <= '0;
      stage_cnt     <= '0;
      idx           <= '0;
      rst_n_out     <= '0;
      seq_done      <= 1'b0;
      lock_loss_cnt <= '0;
    end else if (abort) begin
      deb_cnt   <= '0;
      stage_cnt <= '0;
      idx       <= '0;
      rst_n_out <= '0;
      seq_done  <= 1'b0;
      // One increment per abort even when board reset drops at the same time.
      if (!lock_sync && lock_loss_cnt != LOSS_MAX)
        lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end else begin
      case (state_q)
        ST_DEBOUNCE: begin
          stage_cnt <= '0;
          idx       <= '0;
          if (!good || deb_cnt == DEB_MAX) deb_cnt <= '0;
          else                             deb_cnt <= deb_cnt + 1'b1;
        end
        ST_RELEASE: begin
          if (wrap) begin
            stage_cnt <= '0;
            for (int k = 0; k < NCH; k++)
              if (idx == IW'(k)) rst_n_out[k] <= 1'b1;
            if (last) seq_done <= 1'b1;
            else      idx      <= idx + 1'b1;
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Divider only runs once channel 0 is out of reset; abort clears it alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      div_clk <= 1'b0;
      div_en  <= 1'b0;
    end else if (abort || !rst_n_out[0]) begin
      div_cnt <= '0;
      div_clk <= 1'b0;
      div_en  <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
      div_en  <= (div_cnt == DIV_MAX);
      if (div_cnt == DIV_HALF || div_cnt == DIV_MAX) div_clk <= ~div_clk;
    end
  end

endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset sequencer and clock-enable generator for a single clock domain. It synchronises and debounces the external reset and PLL lock inputs, then releases NCH active-low channel resets in a fixed staggered order. It also generates a divided clock and enable for slow peripherals. It sits immediately after the DCM in the top level and generalises the current one-reset-per-domain, fixed divide-by-2 scheme: channel count, stagger, debounce length and divide ratio are all configurable, and it re-sequences on lock loss.

## Interface
- NCH, 3, number of sequenced reset channels, 1..8
- DEB_LEN, 8, consecutive good cycles required before sequencing starts, ≥1
- STAGE_DLY, 16, cycles between successive channel releases, ≥1
- DIV, 2, divide ratio for div_clk/div_en, even, ≥2
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-high; one clock, no other clock domains
- ext_reset_n  in  1  asynchronous board reset, active-low, may chatter
- pll_lock  in  1  asynchronous PLL/DCM locked indication
- rst_n_out  out  NCH  per-channel reset, active-low, bit k released k-th
- seq_done  out  1  high while all channels released
- div_clk  out  1  50 % duty clock at clk/DIV
- div_en  out  1  one-cycle pulse every DIV cycles
- lock_loss_cnt  out  8  saturating count of lock-loss aborts

## Operation
- Reset values: rst_n_out = 0, seq_done = 0, div_clk = 0, div_en = 0, lock_loss_cnt = 0, FSM in DEBOUNCE, all counters 0.
- Synchronisation: ext_reset_n and pll_lock each pass through a 2-flop synchroniser. good = ext_sync & lock_sync.
- DEBOUNCE: the debounce counter increments on each good cycle and clears on any bad cycle. When it reaches DEB_LEN, the FSM enters RELEASE with stage counter = 0 and idx = 0.
- RELEASE: the stage counter counts to STAGE_DLY−1 and wraps. On each wrap, rst_n_out[idx] is set to 1 and idx increments. When the last channel is released, the FSM goes to RUN and seq_done becomes 1 in the same cycle.
- RUN: all outputs hold.
- Abort: a bad cycle in RELEASE or RUN returns the FSM to DEBOUNCE.
  - On the next edge, all rst_n_out go to 0, seq_done goes to 0, the divider clears, and the counters clear.
  - If lock_sync = 0 in the abort cycle, lock_loss_cnt increments (saturates at 255). A simultaneous ext reset and lock loss increments it once only.
- Divider: a counter 0..DIV−1 runs only while rst_n_out[0] = 1; otherwise the counter, div_clk and div_en are held at 0.
  - div_en = 1 when the counter is at DIV−1.
  - div_clk toggles when the counter is at DIV/2−1 and when it is at DIV−1.
  - DIV = 2 gives the legacy half-rate toggle clock.
- Assertion of reset mid-sequence forces the reset values asynchronously. After reset deasserts, the full sequence restarts from DEBOUNCE.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Input-to-action latency: 2 cycles (synchroniser) + 1 cycle (FSM).
- Release timing, with both inputs high and edge 1 being the first rising edge after reset deasserts: rst_n_out[k] rises at edge 2 + DEB_LEN + STAGE_DLY·(k+1).
- Abort latency: rst_n_out falls 3 edges after the offending input transition reaches the synchroniser input.
- Debounce: a glitch of any length that is visible after synchronisation restarts the DEB_LEN count.
- div_en first pulses DIV cycles after rst_n_out[0] rises.

## Structure
- Package rst_seq_pkg holds:
  - the state enum {ST_DEBOUNCE, ST_RELEASE, ST_RUN};
  - width helpers via $clog2 for the DEB_LEN, STAGE_DLY, NCH and DIV counters;
  - LOSS_CNT_MAX = 255.
- Sub-module sync2 is a 2-flop synchroniser with an asynchronous active-high reset value parameter. It is instantiated twice: reset value 0 for both inputs, so the block starts in the not-good condition.
- FSM, stage logic and divider live in the top module.

## Test plan
- Power-up with defaults, inputs high from reset release -> rst_n_out bits rise at edges 26/42/58; seq_done rises at edge 58; div_en first pulses 2 cycles after edge 26.
- ext_reset_n chatters (low 1 cycle every 5 cycles for 40 cycles), then stays high -> no release until 2+8+16 edges after the last glitch.
- pll_lock drops for 1 cycle in RUN -> all rst_n_out = 0 three edges later; lock_loss_cnt = 1; full re-sequence follows.
- ext_reset_n and pll_lock drop in the same cycle during RELEASE (after channel 0 is released) -> single abort, lock_loss_cnt += 1, released channels return to 0.
- NCH = 1, DIV = 8, STAGE_DLY = 1 -> rst_n_out rises at edge 11; div_clk shows a 4-high/4-low pattern; div_en occurs every 8 cycles.
- Assert reset mid-RELEASE; also force 300 lock losses -> outputs zero immediately on reset; lock_loss_cnt saturates at 255.
